// File: rtl/apb_pkg.sv
// Shared types and constants for the APB completer register file.
// FSM state encoding, byte-offset width of one APB word, wait-counter width.
package apb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } apb_state_e;

  localparam int APB_ALIGN_BITS = 2;
  localparam int WAIT_CNT_W     = 4;

endpackage

// File: rtl/apb_slave_regs.sv
// Register bank behind the APB completer: per-register storage, byte-strobe
// merge and a one-cycle write strobe per register.
module apb_slave_regs #(
  parameter int NUM_REGS   = 8,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [IDX_W-1:0]               wr_idx,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic [DATA_WIDTH/8-1:0]        wr_strb,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int STRB_W = DATA_WIDTH / 8;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    logic                  hit;
    logic                  pulse_q;
    logic [DATA_WIDTH-1:0] q;
    logic [DATA_WIDTH-1:0] merged;

    assign hit = wr_en && (wr_idx == IDX_W'(g));

    // Bytes with a clear strobe keep their old contents.
    always_comb begin
      merged = q;
      for (int b = 0; b < STRB_W; b++)
        if (wr_strb[b]) merged[b*8 +: 8] = wr_data[b*8 +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q       <= '0;
        pulse_q <= 1'b0;
      end else begin
        pulse_q <= hit;
        if (hit) q <= merged;
      end
    end

    assign regs[g*DATA_WIDTH +: DATA_WIDTH] = q;
    assign wr_pulse[g]                      = pulse_q;
  end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer with programmable wait states over a word-addressed register bank.
// Define APB_SLAVE_PSTRB_EN to add the PSTRB byte-strobe input.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 'h1000,
  parameter int                    WAIT_CYCLES = 2,
  parameter logic [NUM_REGS-1:0]   RO_MASK     = 'h80
) (
  input  logic                           i_clk,
  input  logic                           i_reset_n,
  input  logic [ADDR_WIDTH-1:0]          PADDR,
  input  logic                           PWRITE,
  input  logic [DATA_WIDTH-1:0]          PWDATA,
`ifdef APB_SLAVE_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0]        PSTRB,
`endif
  input  logic                           PSELx,
  input  logic                           PENABLE,
  output logic [DATA_WIDTH-1:0]          PRDATA,
  output logic                           PREADY,
  output logic                           PSLVERR,
  output logic [NUM_REGS*DATA_WIDTH-1:0] o_regs,
  output logic [NUM_REGS-1:0]            o_wr_pulse
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  // ---- setup-phase decode ----
  logic [ADDR_WIDTH-1:0] off;
  logic [IDX_W-1:0]      dec_idx;
  logic                  dec_ro;
  logic                  dec_err;
  logic [STRB_W-1:0]     dec_strb;
  logic                  strb_err;

  assign off     = PADDR - BASE_ADDR;
  assign dec_idx = off[IDX_W+APB_ALIGN_BITS-1:APB_ALIGN_BITS];

  always_comb begin
    dec_ro = 1'b0;
    for (int i = 0; i < NUM_REGS; i++)
      if (dec_idx == IDX_W'(i)) dec_ro = RO_MASK[i];
  end

`ifdef APB_SLAVE_PSTRB_EN
  assign dec_strb = PSTRB;
  assign strb_err = PWRITE && (PSTRB == '0);
`else
  assign dec_strb = '1;
  assign strb_err = 1'b0;
`endif

  // Range test first so dec_ro is only trusted for a valid index.
  assign dec_err = (PADDR < BASE_ADDR)
                || ((off >> APB_ALIGN_BITS) >= ADDR_WIDTH'(NUM_REGS))
                || (|PADDR[APB_ALIGN_BITS-1:0])
                || (PWRITE && dec_ro)
                || strb_err;

  // ---- FSM and latched transfer ----
  apb_state_e            state, state_n;
  logic [WAIT_CNT_W-1:0] cnt, cnt_n;
  logic [IDX_W-1:0]      a_idx, a_idx_n;
  logic                  a_write, a_write_n;
  logic                  a_err, a_err_n;
  logic [DATA_WIDTH-1:0] a_wdata, a_wdata_n;
  logic [STRB_W-1:0]     a_strb, a_strb_n;
  logic [DATA_WIDTH-1:0] rdata_n;
  logic                  wr_en;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    a_idx_n   = a_idx;
    a_write_n = a_write;
    a_err_n   = a_err;
    a_wdata_n = a_wdata;
    a_strb_n  = a_strb;
    wr_en     = 1'b0;
    rdata_n   = '0;

    case (state)
      S_IDLE: begin
        if (PSELx && !PENABLE) begin
          a_idx_n   = dec_idx;
          a_write_n = PWRITE;
          a_err_n   = dec_err;
          a_wdata_n = PWDATA;
          a_strb_n  = dec_strb;
          cnt_n     = WAIT_CNT_W'(WAIT_CYCLES);
          state_n   = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!PSELx) begin
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
          if (cnt == WAIT_CNT_W'(1)) state_n = S_RESP;
        end
      end
      S_RESP: begin
        state_n = S_IDLE;
        wr_en   = PSELx && a_write && !a_err;
      end
      default: state_n = S_IDLE;
    endcase

    // Read data is fetched on the edge that enters RESP so PRDATA is a flop.
    if (state_n == S_RESP && !a_err_n && !a_write_n)
      for (int i = 0; i < NUM_REGS; i++)
        if (a_idx_n == IDX_W'(i)) rdata_n = o_regs[i*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      a_idx   <= '0;
      a_write <= 1'b0;
      a_err   <= 1'b0;
      a_wdata <= '0;
      a_strb  <= '0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      a_idx   <= a_idx_n;
      a_write <= a_write_n;
      a_err   <= a_err_n;
      a_wdata <= a_wdata_n;
      a_strb  <= a_strb_n;
      PREADY  <= (state_n == S_RESP);
      PSLVERR <= (state_n == S_RESP) && a_err_n;
      PRDATA  <= rdata_n;
    end
  end

  apb_slave_regs #(
    .NUM_REGS   (NUM_REGS),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_regs (
    .clk      (i_clk),
    .rst_n    (i_reset_n),
    .wr_en    (wr_en),
    .wr_idx   (a_idx),
    .wr_data  (a_wdata),
    .wr_strb  (a_strb),
    .regs     (o_regs),
    .wr_pulse (o_wr_pulse)
  );

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile at default parameters; PSTRB step runs
// only when APB_SLAVE_PSTRB_EN is defined.
module tb_apb_slave_regfile;

  logic         i_clk = 1'b0;
  logic         i_reset_n;
  logic [31:0]  PADDR;
  logic         PWRITE;
  logic [31:0]  PWDATA;
`ifdef APB_SLAVE_PSTRB_EN
  logic [3:0]   PSTRB;
`endif
  logic         PSELx;
  logic         PENABLE;
  logic [31:0]  PRDATA;
  logic         PREADY;
  logic         PSLVERR;
  logic [255:0] o_regs;
  logic [7:0]   o_wr_pulse;

  int checks = 0;
  int errors = 0;
  logic [255:0] exp_regs;
  logic [31:0]  rd;
  logic         err;
  int           lat;

  always #5 i_clk = ~i_clk;

  apb_slave_regfile dut (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .PADDR      (PADDR),
    .PWRITE     (PWRITE),
    .PWDATA     (PWDATA),
`ifdef APB_SLAVE_PSTRB_EN
    .PSTRB      (PSTRB),
`endif
    .PSELx      (PSELx),
    .PENABLE    (PENABLE),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR),
    .o_regs     (o_regs),
    .o_wr_pulse (o_wr_pulse)
  );

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Setup in the current cycle, access until PREADY (bounded), then release.
  // Returns in the cycle after RESP with the bus idle.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                      output logic [31:0] rdata, output logic slverr, output int cycles);
    PADDR = addr; PWRITE = wr; PWDATA = wd;
    PSELx = 1'b1; PENABLE = 1'b0;
    cycles = 0; rdata = '0; slverr = 1'b0;
    while (cycles < 20) begin
      step();
      cycles++;
      PENABLE = 1'b1;
      if (PREADY) break;
    end
    rdata  = PRDATA;
    slverr = PSLVERR;
    step();
    PSELx = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    i_reset_n = 1'b0;
    PADDR = '0; PWRITE = 1'b0; PWDATA = '0; PSELx = 1'b0; PENABLE = 1'b0;
`ifdef APB_SLAVE_PSTRB_EN
    PSTRB = 4'hF;
`endif
    exp_regs = '0;
    step(); step();
    chk("rst_pready", PREADY, 0);
    chk("rst_pslverr", PSLVERR, 0);
    chk("rst_prdata", PRDATA, 0);
    chk("rst_regs", o_regs, 0);
    chk("rst_pulse", o_wr_pulse, 0);
    i_reset_n = 1'b1;
    step();

    // 1: write reg0
    xfer(32'h1000, 1'b1, 32'hDEADBEEF, rd, err, lat);
    exp_regs[31:0] = 32'hDEADBEEF;
    chk("w0_lat", lat, 3);
    chk("w0_err", err, 0);
    chk("w0_regs", o_regs, exp_regs);
    chk("w0_pulse", o_wr_pulse, 8'h01);
    chk("w0_ready_drop", PREADY, 0);
    step();
    chk("w0_pulse_once", o_wr_pulse, 8'h00);

    // 2: read back, then back-to-back write/read of reg1
    xfer(32'h1000, 1'b0, 32'h0, rd, err, lat);
    chk("r0_lat", lat, 3);
    chk("r0_data", rd, 32'hDEADBEEF);
    chk("r0_err", err, 0);
    chk("r0_prdata_idle", PRDATA, 0);
    xfer(32'h1004, 1'b1, 32'hCAFEBABE, rd, err, lat);
    exp_regs[63:32] = 32'hCAFEBABE;
    chk("w1_pulse", o_wr_pulse, 8'h02);
    xfer(32'h1004, 1'b0, 32'h0, rd, err, lat);
    chk("r1_lat", lat, 3);
    chk("r1_data", rd, 32'hCAFEBABE);
    chk("r1_regs", o_regs, exp_regs);

    // 3: out-of-range write, read of the read-only register
    xfer(32'h3000, 1'b1, 32'h0BADF00D, rd, err, lat);
    chk("woor_err", err, 1);
    chk("woor_pulse", o_wr_pulse, 0);
    chk("woor_regs", o_regs, exp_regs);
    xfer(32'h101C, 1'b0, 32'h0, rd, err, lat);
    chk("rro_err", err, 0);
    chk("rro_data", rd, 0);

    // 4: read-only write, misaligned write, below-base read
    xfer(32'h101C, 1'b1, 32'h55AA55AA, rd, err, lat);
    chk("wro_err", err, 1);
    chk("wro_pulse", o_wr_pulse, 0);
    xfer(32'h1002, 1'b1, 32'h77777777, rd, err, lat);
    chk("wmis_err", err, 1);
    chk("wmis_pulse", o_wr_pulse, 0);
    chk("wmis_regs", o_regs, exp_regs);
    xfer(32'h0FFC, 1'b0, 32'h0, rd, err, lat);
    chk("rlow_err", err, 1);
    chk("rlow_data", rd, 0);

    // Access phase without a setup is ignored
    PADDR = 32'h1000; PWRITE = 1'b0; PSELx = 1'b1; PENABLE = 1'b1;
    step(); chk("nosetup_rdy1", PREADY, 0);
    step(); chk("nosetup_rdy2", PREADY, 0);
    step(); chk("nosetup_rdy3", PREADY, 0);
    PSELx = 1'b0; PENABLE = 1'b0;
    step();

    // 5a: abort in WAIT, no write
    PADDR = 32'h1008; PWRITE = 1'b1; PWDATA = 32'h12345678; PSELx = 1'b1; PENABLE = 1'b0;
    step(); PENABLE = 1'b1;
    step(); PSELx = 1'b0; PENABLE = 1'b0;
    step(); chk("abort_rdy1", PREADY, 0);
    step(); chk("abort_rdy2", PREADY, 0);
    chk("abort_pulse", o_wr_pulse, 0);
    chk("abort_regs", o_regs, exp_regs);
    xfer(32'h1008, 1'b0, 32'h0, rd, err, lat);
    chk("abort_rd", rd, 0);

    // 5b: asynchronous reset mid-WAIT
    PADDR = 32'h1000; PWRITE = 1'b0; PSELx = 1'b1; PENABLE = 1'b0;
    step(); PENABLE = 1'b1;
    #2 i_reset_n = 1'b0;
    #1;
    chk("arst_regs", o_regs, 0);
    chk("arst_rdy", PREADY, 0);
    step();
    PSELx = 1'b0; PENABLE = 1'b0; i_reset_n = 1'b1;
    exp_regs = '0;
    step();
    xfer(32'h1000, 1'b0, 32'h0, rd, err, lat);
    chk("arst_lat", lat, 3);
    chk("arst_rd", rd, 0);

`ifdef APB_SLAVE_PSTRB_EN
    // 6: byte strobes
    xfer(32'h1000, 1'b1, 32'hDEADBEEF, rd, err, lat);
    PSTRB = 4'b0011;
    xfer(32'h1000, 1'b1, 32'h11223344, rd, err, lat);
    exp_regs[31:0] = 32'hDEAD3344;
    chk("strb_err", err, 0);
    chk("strb_regs", o_regs, exp_regs);
    PSTRB = 4'b0000;
    xfer(32'h1000, 1'b1, 32'hFFFFFFFF, rd, err, lat);
    chk("strb0_err", err, 1);
    chk("strb0_regs", o_regs, exp_regs);
    PSTRB = 4'hF;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
